// File: rtl/branch_predictor_pkg.sv
// Shared sizing defaults and 2-bit PHT counter encodings
// for the IF-stage gshare branch predictor.
package branch_predictor_pkg;

    localparam int IDX_BITS_DEF = 5;
    localparam int TAG_BITS_DEF = 30 - IDX_BITS_DEF;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_t;

    localparam pht_state_t PHT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function
// used on the PHT training path.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  pht_state_t count,
    input  logic       up,
    output pht_state_t next
);

    always_comb begin
        next = count;
        if (up) begin
            if (count != ST) next = pht_state_t'(count + 2'd1);
        end else begin
            if (count != SNT) next = pht_state_t'(count - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB plus gshare PHT,
// trained by resolved control instructions from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         current_pc,
    output logic [31:0]         pred_next_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_ghr,
    input  logic                update_valid,
    input  logic                update_is_jump,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic [IDX_BITS-1:0] update_ghr
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic                valid    [ENTRIES];
    logic                jump_bit [ENTRIES];
    logic [TAG_BITS-1:0] tag      [ENTRIES];
    logic [31:0]         target   [ENTRIES];
    pht_state_t          pht      [ENTRIES];
    logic [IDX_BITS-1:0] ghr;

    logic [IDX_BITS-1:0] bi;
    logic [IDX_BITS-1:0] pi;
    logic [IDX_BITS-1:0] ui;
    logic [IDX_BITS-1:0] uj;
    logic                hit;
    logic [1:0]          pred_cnt;
    pht_state_t          pht_next;
    logic                btb_write;
    logic                pht_write;

    assign bi       = current_pc[IDX_BITS+1:2];
    assign pi       = bi ^ ghr;
    assign hit      = valid[bi] && (tag[bi] == current_pc[31:IDX_BITS+2]);
    assign pred_cnt = pht[pi];

    assign pred_taken   = hit && (jump_bit[bi] || pred_cnt[1]);
    assign pred_next_pc = pred_taken ? target[bi] : current_pc + 32'd4;
    assign pred_ghr     = ghr;

    assign ui = update_pc[IDX_BITS+1:2];
    assign uj = ui ^ update_ghr;

    // Jumps always allocate, even if the caller forgets to force taken.
    assign btb_write = update_valid && (update_taken || update_is_jump);
    assign pht_write = update_valid && !update_is_jump;

    sat_counter2 u_sat (
        .count (pht[uj]),
        .up    (update_taken),
        .next  (pht_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]    <= 1'b0;
                jump_bit[i] <= 1'b0;
                pht[i]      <= PHT_RESET;
            end
            ghr <= '0;
        end else begin
            if (pht_write) begin
                pht[uj] <= pht_next;
                ghr     <= {ghr[IDX_BITS-2:0], update_taken};
            end
            if (btb_write) begin
                valid[ui]    <= 1'b1;
                jump_bit[ui] <= update_is_jump;
            end
        end
    end

    // Tag/target payload needs no reset; valid gates its use.
    always_ff @(posedge clk) begin
        if (!reset && btb_write) begin
            tag[ui]    <= update_pc[31:IDX_BITS+2];
            target[ui] <= update_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: hand-derived
// predictions queued per step, compared against the combinational outputs.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic [4:0]  pred_ghr;
    logic        update_valid;
    logic        update_is_jump;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [4:0]  update_ghr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        taken;
        logic [31:0] next_pc;
        logic [4:0]  ghr;
        string       name;
    } exp_t;

    exp_t sb[$];

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .pred_next_pc   (pred_next_pc),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .update_valid   (update_valid),
        .update_is_jump (update_is_jump),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_ghr     (update_ghr)
    );

    always #5 clk = ~clk;

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (pred_taken === e.taken) else begin
            bad++;
            $error("FAIL %s taken got=%0b want=%0b", e.name, pred_taken, e.taken);
        end
        total++;
        assert (pred_next_pc === e.next_pc) else begin
            bad++;
            $error("FAIL %s next_pc got=%h want=%h", e.name, pred_next_pc, e.next_pc);
        end
        total++;
        assert (pred_ghr === e.ghr) else begin
            bad++;
            $error("FAIL %s ghr got=%b want=%b", e.name, pred_ghr, e.ghr);
        end
    endtask

    // Drive one cycle at negedge, queue the expectation, check 1ns later.
    task automatic step(
        input logic        rst,
        input logic [31:0] pc,
        input logic        uv,
        input logic        uj,
        input logic [31:0] upc,
        input logic        ut,
        input logic [31:0] utgt,
        input logic [4:0]  ughr,
        input logic        et,
        input logic [31:0] en,
        input logic [4:0]  eg,
        input string       name
    );
        exp_t e;
        @(negedge clk);
        reset          = rst;
        current_pc     = pc;
        update_valid   = uv;
        update_is_jump = uj;
        update_pc      = upc;
        update_taken   = ut;
        update_target  = utgt;
        update_ghr     = ughr;
        e.taken   = et;
        e.next_pc = en;
        e.ghr     = eg;
        e.name    = name;
        sb.push_back(e);
        #1;
        check_front();
    endtask

    initial begin
        reset          = 1'b1;
        current_pc     = 32'h0;
        update_valid   = 1'b0;
        update_is_jump = 1'b0;
        update_pc      = 32'h0;
        update_taken   = 1'b0;
        update_target  = 32'h0;
        update_ghr     = 5'd0;
        repeat (2) @(posedge clk);

        // rst pc        uv uj upc          ut utgt         ughr  et nxt          ghr
        step(0, 32'h100, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h104,    5'd0, "reset_state");
        step(0, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 32'h0,      5'd0, 0, 32'h0,      5'd0, "pc_wrap");
        step(0, 32'h100, 1, 1, 32'h200,    1, 32'h480,    5'd0, 0, 32'h104,    5'd0, "jump_upd");
        step(0, 32'h200, 0, 0, 32'h0,      0, 32'h0,      5'd0, 1, 32'h480,    5'd0, "jump_hit");
        step(0, 32'h100, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h104,    5'd0, "tag_miss");
        step(0, 32'h200, 1, 0, 32'h300,    1, 32'h340,    5'd0, 1, 32'h480,    5'd0, "br_upd1");
        step(0, 32'h200, 1, 0, 32'h300,    1, 32'h340,    5'd0, 0, 32'h204,    5'd1, "br_upd2");
        step(0, 32'h300, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h304,    5'd3, "fresh_idx");
        step(0, 32'h100, 1, 0, 32'h304,    1, 32'h500,    5'd8, 0, 32'h104,    5'd3, "alloc_304");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd7, "nt1");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd14, "nt2");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd28, "nt3");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd24, "nt4");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd16, "nt5");
        step(0, 32'h304, 1, 0, 32'h304,    0, 32'h0,      5'd0, 0, 32'h308,    5'd0, "nt6");
        step(0, 32'h304, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h308,    5'd0, "sat_low");
        step(0, 32'h300, 1, 0, 32'h304,    1, 32'h500,    5'd0, 1, 32'h340,    5'd0, "trained_idx");
        step(0, 32'h300, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h304,    5'd1, "inc_from_00");
        step(0, 32'h300, 1, 0, 32'h1300,   1, 32'h1340,   5'd3, 0, 32'h304,    5'd1, "conflict_upd");
        step(0, 32'h300, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h304,    5'd3, "evicted");
        step(0, 32'h1300, 0, 0, 32'h0,     0, 32'h0,      5'd0, 1, 32'h1340,   5'd3, "conflict_hit");
        step(0, 32'h200, 1, 1, 32'h200,    1, 32'h480,    5'd0, 0, 32'h204,    5'd3, "same_cyc_old");
        step(0, 32'h200, 0, 0, 32'h0,      0, 32'h0,      5'd0, 1, 32'h480,    5'd3, "same_cyc_new");
        step(0, 32'h1300, 0, 0, 32'h0,     0, 32'h0,      5'd0, 0, 32'h1304,   5'd3, "replaced");
        step(1, 32'h200, 1, 1, 32'h104,    1, 32'h900,    5'd0, 1, 32'h480,    5'd3, "rst_cycle");
        step(0, 32'h200, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h204,    5'd0, "rst_clr_200");
        step(0, 32'h104, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h108,    5'd0, "rst_no_upd");
        step(0, 32'h304, 0, 0, 32'h0,      0, 32'h0,      5'd0, 0, 32'h308,    5'd0, "rst_clr_304");
        step(0, 32'h1300, 0, 0, 32'h0,     0, 32'h0,      5'd0, 0, 32'h1304,   5'd0, "rst_clr_1300");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
